// File: rtl/apb_master_arb17.sv
// Two-requester APB master with round-robin arbitration and an ACCESS-phase timeout.
// One transfer in flight; the response pulse coincides with IDLE so back-to-back accepts work.
module apb_master_arb17 #(
  parameter int unsigned PADDR_WIDTH17  = 32,
  parameter int unsigned PWDATA_WIDTH17 = 32,
  parameter int unsigned TIMEOUT17      = 16
) (
  input  logic                        pclock17,
  input  logic                        preset17,
  input  logic [1:0]                  req_valid17,
  input  logic [1:0]                  req_wr17,
  input  logic [2*PADDR_WIDTH17-1:0]  req_addr17,
  input  logic [2*PWDATA_WIDTH17-1:0] req_wdata17,
  output logic [1:0]                  req_ready17,
  output logic [1:0]                  rsp_valid17,
  output logic [PWDATA_WIDTH17-1:0]   rsp_rdata17,
  output logic                        rsp_err17,
  output logic [PADDR_WIDTH17-1:0]    paddr17,
  output logic                        prwd17,
  output logic [PWDATA_WIDTH17-1:0]   pwdata17,
  output logic                        psel17,
  output logic                        penable17,
  input  logic [PWDATA_WIDTH17-1:0]   prdata17,
  input  logic                        pready17,
  input  logic                        pslverr17
);

  localparam int unsigned AW = PADDR_WIDTH17;
  localparam int unsigned DW = PWDATA_WIDTH17;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            gnt_c;
  logic            accept_c;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    gnt_c = req_valid17[1];
    if (req_valid17[0] && req_valid17[1]) gnt_c = ptr_q;
    req_ready17 = 2'b00;
    if ((state_q == IDLE) && preset17 && req_valid17[gnt_c])
      req_ready17 = gnt_c ? 2'b10 : 2'b01;
    accept_c = |(req_valid17 & req_ready17);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SETUP;
          owner_d = gnt_c;
          ptr_d   = ~gnt_c;
          wr_d    = req_wr17[gnt_c];
          addr_d  = gnt_c ? req_addr17[2*AW-1:AW] : req_addr17[AW-1:0];
          wdata_d = gnt_c ? req_wdata17[2*DW-1:DW] : req_wdata17[DW-1:0];
          wait_d  = '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready17) begin
          state_d     = IDLE;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_err_d   = pslverr17;
          rsp_rdata_d = wr_q ? '0 : prdata17;
        end else begin
          wait_d = wait_q + CW'(1);
          // The cycle that brings the count to TIMEOUT17 is the last ACCESS cycle.
          if (wait_q == CW'(TIMEOUT17 - 1)) begin
            state_d     = IDLE;
            rsp_valid_d = owner_q ? 2'b10 : 2'b01;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclock17 or negedge preset17) begin
    if (!preset17) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr17     = addr_q;
  assign prwd17      = wr_q;
  assign pwdata17    = wdata_q;
  assign psel17      = psel_q;
  assign penable17   = penable_q;
  assign rsp_valid17 = rsp_valid_q;
  assign rsp_rdata17 = rsp_rdata_q;
  assign rsp_err17   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb17.sv
// Directed bench for apb_master_arb17: latency, waits, round-robin, timeout, slave error, reset.
module tb_apb_master_arb17;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_wr = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          prwd;
  logic [DW-1:0] pwdata;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b1;
  logic          pslverr = 1'b0;

  int ntot = 0;
  int nbad = 0;

  apb_master_arb17 #(.PADDR_WIDTH17(AW), .PWDATA_WIDTH17(DW), .TIMEOUT17(16)) dut (
    .pclock17(clk), .preset17(rst_n),
    .req_valid17(req_valid), .req_wr17(req_wr), .req_addr17(req_addr), .req_wdata17(req_wdata),
    .req_ready17(req_ready), .rsp_valid17(rsp_valid), .rsp_rdata17(rsp_rdata), .rsp_err17(rsp_err),
    .paddr17(paddr), .prwd17(prwd), .pwdata17(pwdata), .psel17(psel), .penable17(penable),
    .prdata17(prdata), .pready17(pready), .pslverr17(pslverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    #1;
    ntot++;
    if ({req_ready, rsp_valid, psel, penable, prwd, rsp_err} !== 8'b0) begin
      nbad++; $display("FAIL reset_ctl got=%b exp=0", {req_ready, rsp_valid, psel, penable, prwd, rsp_err});
    end
    ntot++;
    if ({paddr, pwdata, rsp_rdata} !== '0) begin
      nbad++; $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp=0", paddr, pwdata, rsp_rdata);
    end
    tick(); tick();
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    pready = 1'b1;
    req_valid = 2'b01; req_wr = 2'b01;
    req_addr[AW-1:0] = 32'h10; req_wdata[DW-1:0] = 32'hA5A5A5A5;
    #1;
    ntot++;
    if (req_ready !== 2'b01) begin nbad++; $display("FAIL wr_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    req_addr[AW-1:0] = 32'hFFFF; req_wdata[DW-1:0] = 32'h0; req_wr = 2'b00;
    ntot++;
    if ({psel, penable, rsp_valid} !== 4'b1000) begin
      nbad++; $display("FAIL wr_setup got=%b exp=1000", {psel, penable, rsp_valid});
    end
    ntot++;
    if ({paddr, prwd, pwdata} !== {32'h10, 1'b1, 32'hA5A5A5A5}) begin
      nbad++; $display("FAIL wr_payload got addr=%h wr=%b data=%h exp 10/1/a5a5a5a5", paddr, prwd, pwdata);
    end
    tick();
    ntot++;
    if ({psel, penable, rsp_valid, paddr} !== {4'b1100, 32'h10}) begin
      nbad++; $display("FAIL wr_access got sel/en/rv=%b addr=%h exp 1100/10", {psel, penable, rsp_valid}, paddr);
    end
    tick();
    ntot++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, penable} !== {2'b01, 1'b0, 32'h0, 2'b00}) begin
      nbad++; $display("FAIL wr_rsp got rv=%b err=%b rdata=%h sel=%b en=%b exp 01/0/0/0/0",
                       rsp_valid, rsp_err, rsp_rdata, psel, penable);
    end
    tick();
    ntot++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      nbad++; $display("FAIL wr_rsp_pulse got rv=%b err=%b rdata=%h exp 0", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_read_wait();
    int acc;
    pready = 1'b0; prdata = 32'h0;
    req_valid = 2'b10; req_wr = 2'b00;
    req_addr[2*AW-1:AW] = 32'h20;
    #1;
    ntot++;
    if (req_ready !== 2'b10) begin nbad++; $display("FAIL rd_ready got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    ntot++;
    if ({psel, penable, paddr, prwd} !== {2'b10, 32'h20, 1'b0}) begin
      nbad++; $display("FAIL rd_setup got sel/en=%b addr=%h wr=%b exp 10/20/0", {psel, penable}, paddr, prwd);
    end
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (psel && penable && rsp_valid == 2'b00) acc++;
      if (i == 3) begin pready = 1'b1; prdata = 32'h12345678; end
    end
    ntot++;
    if (acc !== 4) begin nbad++; $display("FAIL rd_access_len got=%0d exp=4", acc); end
    tick();
    ntot++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel} !== {2'b10, 1'b0, 32'h12345678, 1'b0}) begin
      nbad++; $display("FAIL rd_rsp got rv=%b err=%b rdata=%h sel=%b exp 10/0/12345678/0",
                       rsp_valid, rsp_err, rsp_rdata, psel);
    end
    prdata = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rv;
    pready = 1'b1; prdata = 32'hDEADBEEF;
    req_wr = 2'b01;
    req_addr = {32'h200, 32'h100};
    req_wdata = {32'h0, 32'h55};
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rv = (k % 2 == 0) ? 2'b01 : 2'b10;
      ntot++;
      if (req_ready !== exp_rv) begin nbad++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, req_ready, exp_rv); end
      tick();
      ntot++;
      if ({psel, penable, paddr} !== {2'b10, (k % 2 == 0) ? 32'h100 : 32'h200}) begin
        nbad++; $display("FAIL b2b_setup%0d got sel/en=%b addr=%h", k, {psel, penable}, paddr);
      end
      tick();
      tick();
      if (k == 3) req_valid = 2'b00;
      ntot++;
      if ({rsp_valid, rsp_rdata} !== {exp_rv, (k % 2 == 0) ? 32'h0 : 32'hDEADBEEF}) begin
        nbad++; $display("FAIL b2b_rsp%0d got rv=%b rdata=%h exp rv=%b", k, rsp_valid, rsp_rdata, exp_rv);
      end
    end
    prdata = 32'h0;
  endtask

  task automatic test_timeout();
    int acc;
    pready = 1'b0; prdata = 32'hFFFFFFFF;
    req_valid = 2'b01; req_wr = 2'b00; req_addr[AW-1:0] = 32'h30;
    #1;
    tick();
    req_valid = 2'b00;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (psel && penable) acc++;
    end
    ntot++;
    if (acc !== 16) begin nbad++; $display("FAIL to_access_len got=%0d exp=16", acc); end
    tick();
    ntot++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, penable} !== {2'b01, 1'b1, 32'h0, 2'b00}) begin
      nbad++; $display("FAIL to_rsp got rv=%b err=%b rdata=%h sel=%b en=%b exp 01/1/0/0/0",
                       rsp_valid, rsp_err, rsp_rdata, psel, penable);
    end
    pready = 1'b1; prdata = 32'h0;
  endtask

  task automatic test_slverr();
    pready = 1'b1; pslverr = 1'b1;
    req_valid = 2'b10; req_wr = 2'b10; req_addr[2*AW-1:AW] = 32'h40;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    ntot++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b1, 32'h0}) begin
      nbad++; $display("FAIL slverr_rsp got rv=%b err=%b rdata=%h exp 10/1/0", rsp_valid, rsp_err, rsp_rdata);
    end
    pslverr = 1'b0;
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    req_valid = 2'b01; req_wr = 2'b00; req_addr = {32'h88, 32'h77};
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    ntot++;
    if ({psel, penable} !== 2'b11) begin nbad++; $display("FAIL rm_access got=%b exp=11", {psel, penable}); end
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    ntot++;
    if ({psel, penable, req_ready, rsp_valid, paddr} !== '0) begin
      nbad++; $display("FAIL rm_async got sel/en/rdy/rv=%b addr=%h exp 0", {psel, penable, req_ready, rsp_valid}, paddr);
    end
    tick();
    pready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    ntot++;
    if (req_ready !== 2'b01) begin nbad++; $display("FAIL rm_ptr got=%b exp=01", req_ready); end
    @(posedge clk);
    #2;
    req_valid = 2'b00;
    ntot++;
    if ({psel, penable, paddr, rsp_valid} !== {2'b10, 32'h77, 2'b00}) begin
      nbad++; $display("FAIL rm_first got sel/en=%b addr=%h rv=%b exp 10/77/00", {psel, penable}, paddr, rsp_valid);
    end
    tick();
    tick();
    ntot++;
    if (rsp_valid !== 2'b01) begin nbad++; $display("FAIL rm_rsp got=%b exp=01", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
